// File: rtl/seg_mux_disp.sv
// Time-multiplexed seven-segment driver: hex decode, per-digit blanking and
// decimal points, with a programmable all-dark gap between digit slots.
module seg_mux_disp #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned REFRESH_DIV    = 24000,
    parameter int unsigned DEAD_CYCLES    = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [4*NUM_DIGITS-1:0]                          digits,
    input  logic [NUM_DIGITS-1:0]                            blank,
    input  logic [NUM_DIGITS-1:0]                            dp_in,
    output logic [6:0]                                       seg,
    output logic                                             dp,
    output logic [NUM_DIGITS-1:0]                            an,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

    localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CMAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]         SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    typedef enum logic [0:0] {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_d;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic                  load;
    logic [3:0]            nib;
    logic                  blk;
    logic                  dpi;
    logic [NUM_DIGITS-1:0] onehot;

    // Logical ABCDEFG pattern, 1 = lit.
    function automatic logic [6:0] hex_pattern(input logic [3:0] v);
        case (v)
            4'h0: hex_pattern = 7'b1111110;
            4'h1: hex_pattern = 7'b0110000;
            4'h2: hex_pattern = 7'b1101101;
            4'h3: hex_pattern = 7'b1111001;
            4'h4: hex_pattern = 7'b0110011;
            4'h5: hex_pattern = 7'b1011011;
            4'h6: hex_pattern = 7'b1011111;
            4'h7: hex_pattern = 7'b1110000;
            4'h8: hex_pattern = 7'b1111111;
            4'h9: hex_pattern = 7'b1111011;
            4'hA: hex_pattern = 7'b1110111;
            4'hB: hex_pattern = 7'b0011111;
            4'hC: hex_pattern = 7'b1001110;
            4'hD: hex_pattern = 7'b0111101;
            4'hE: hex_pattern = 7'b1001111;
            4'hF: hex_pattern = 7'b1000111;
        endcase
    endfunction

    // Next state, slot counter and digit index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = digit_idx;
        load    = 1'b0;
        case (state_q)
            ST_DEAD: begin
                if (DEAD_CYCLES == 0 || cnt_q == DEAD_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    idx_d = (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
                    if (DEAD_CYCLES > 0) begin
                        state_d = ST_DEAD;
                    end else begin
                        load = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_DEAD;
                cnt_d   = '0;
            end
        endcase
    end

    // Pick the slot's digit fields using the next index so outputs align with the latch edge.
    always_comb begin
        nib = 4'h0;
        blk = 1'b0;
        dpi = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_d == IW'(i)) begin
                nib = digits[4*i +: 4];
                blk = blank[i];
                dpi = dp_in[i];
            end
        end
        onehot = NUM_DIGITS'(1) << idx_d;
    end

    // Output values are held between latches, so mid-slot input changes are invisible.
    always_comb begin
        seg_d = seg;
        dp_d  = dp;
        an_d  = an;
        if (state_d == ST_DEAD) begin
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
            an_d  = AN_OFF;
        end else if (load) begin
            seg_d = blk ? SEG_OFF : (hex_pattern(nib) ^ {7{SEG_ACTIVE_LOW}});
            dp_d  = (dpi & ~blk) ^ SEG_ACTIVE_LOW;
            an_d  = onehot ^ AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_DEAD;
            cnt_q     <= '0;
            digit_idx <= '0;
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
            an        <= AN_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_idx <= idx_d;
            seg       <= seg_d;
            dp        <= dp_d;
            an        <= an_d;
        end
    end

endmodule

// File: tb/tb_seg_mux_disp.sv
// Directed bench for seg_mux_disp: a 4-digit/2-dead-cycle instance and a
// single-digit zero-dead-time instance, checked against queued slot expectations.
module tb_seg_mux_disp;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } slot_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    logic        reset1;
    logic [3:0]  digits1;
    logic        blank1;
    logic        dp_in1;
    logic [6:0]  seg1;
    logic        dp1;
    logic        an1;
    logic        digit_idx1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    slot_t      sb[$];
    logic [6:0] sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_mux_disp #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .digits(digits), .blank(blank), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
    );

    seg_mux_disp #(
        .NUM_DIGITS(1), .REFRESH_DIV(8), .DEAD_CYCLES(0),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(reset1), .digits(digits1), .blank(blank1), .dp_in(dp_in1),
        .seg(seg1), .dp(dp1), .an(an1), .digit_idx(digit_idx1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t mk(input logic [3:0] a, input logic [6:0] s,
                                 input logic d, input logic [1:0] i);
        slot_t r;
        r.an  = a;
        r.seg = s;
        r.dp  = d;
        r.idx = i;
        return r;
    endfunction

    task automatic push_frame_1a3f();
        sb.push_back(mk(4'b1110, 7'b0111000, 1'b1, 2'd0));
        sb.push_back(mk(4'b1101, 7'b0000110, 1'b1, 2'd1));
        sb.push_back(mk(4'b1011, 7'b0001000, 1'b1, 2'd2));
        sb.push_back(mk(4'b0111, 7'b1001111, 1'b1, 2'd3));
    endtask

    // Waits for the next lit slot, checks it against the queue head, its 8-cycle hold and the gap after it.
    task automatic check_slot(input bit do_change, input logic [15:0] new_digits, output int start);
        slot_t e;
        slot_t o;
        bit    held;
        int    w;
        e = sb.pop_front();
        w = 0;
        while (an === 4'hF && w < 12) begin
            tick();
            w++;
        end
        chk("slot_lit", 32'(an !== 4'hF), 32'd1);
        start = cyc;
        o = {an, seg, dp, digit_idx};
        chk("slot_val", 32'(o), 32'(e));
        held = 1'b1;
        for (int k = 1; k < 8; k++) begin
            if (do_change && k == 3) digits = new_digits;
            tick();
            if ({an, seg, dp, digit_idx} !== e) held = 1'b0;
        end
        chk("slot_hold", 32'(held), 32'd1);
        tick();
        chk("slot_gap", 32'({an, seg, dp}), 32'(12'hFFF));
    endtask

    initial begin
        int    t0;
        int    t4;
        int    ts;
        int    w;
        bit    ok;
        bit    an_ok;
        logic [6:0] e1;

        reset   = 1'b1;
        reset1  = 1'b1;
        digits  = 16'h1A3F;
        blank   = 4'b0000;
        dp_in   = 4'b0000;
        digits1 = 4'h3;
        blank1  = 1'b0;
        dp_in1  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_an", 32'(an), 32'(4'b1111));
        chk("rst_seg", 32'(seg), 32'(7'b1111111));
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        chk("rst1_an", 32'(an1), 32'd1);

        // Normal refresh of 1A3F and frame length
        reset = 1'b0;
        tick();
        chk("edge1_dark", 32'(an), 32'(4'b1111));
        push_frame_1a3f();
        check_slot(1'b0, 16'h0, t0);
        repeat (3) check_slot(1'b0, 16'h0, ts);
        sb.push_back(mk(4'b1110, 7'b0111000, 1'b1, 2'd0));
        check_slot(1'b0, 16'h0, t4);
        chk("frame_len", 32'(t4 - t0), 32'd40);

        // Mid-slot digit change is not visible until the next latch
        sb.push_back(mk(4'b1101, 7'b0000110, 1'b1, 2'd1));
        sb.push_back(mk(4'b1011, 7'b0001000, 1'b1, 2'd2));
        sb.push_back(mk(4'b0111, 7'b1001111, 1'b1, 2'd3));
        repeat (3) check_slot(1'b0, 16'h0, ts);
        sb.push_back(mk(4'b1110, 7'b0111000, 1'b1, 2'd0));
        check_slot(1'b1, 16'h1A38, ts);
        sb.push_back(mk(4'b1101, 7'b0000110, 1'b1, 2'd1));
        sb.push_back(mk(4'b1011, 7'b0001000, 1'b1, 2'd2));
        sb.push_back(mk(4'b0111, 7'b1001111, 1'b1, 2'd3));
        sb.push_back(mk(4'b1110, 7'b0000000, 1'b1, 2'd0));
        repeat (4) check_slot(1'b0, 16'h0, ts);

        // Blanking overrides dp; dp on an unblanked digit
        blank = 4'b0010;
        dp_in = 4'b0011;
        sb.push_back(mk(4'b1101, 7'b1111111, 1'b1, 2'd1));
        sb.push_back(mk(4'b1011, 7'b0001000, 1'b1, 2'd2));
        sb.push_back(mk(4'b0111, 7'b1001111, 1'b1, 2'd3));
        sb.push_back(mk(4'b1110, 7'b0000000, 1'b0, 2'd0));
        repeat (4) check_slot(1'b0, 16'h0, ts);

        // Reset in the middle of digit 2 and clean restart
        blank  = 4'b0000;
        dp_in  = 4'b0000;
        digits = 16'h1A3F;
        sb.push_back(mk(4'b1101, 7'b0000110, 1'b1, 2'd1));
        check_slot(1'b0, 16'h0, ts);
        w = 0;
        while (an === 4'hF && w < 12) begin
            tick();
            w++;
        end
        chk("mid_lit_an", 32'(an), 32'(4'b1011));
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_an", 32'(an), 32'(4'b1111));
        chk("mid_rst_seg", 32'(seg), 32'(7'b1111111));
        chk("mid_rst_dp", 32'(dp), 32'd1);
        chk("mid_rst_idx", 32'(digit_idx), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("restart_dark", 32'(an), 32'(4'b1111));
        push_frame_1a3f();
        check_slot(1'b0, 16'h0, t0);
        repeat (3) check_slot(1'b0, 16'h0, ts);
        sb.push_back(mk(4'b1110, 7'b0111000, 1'b1, 2'd0));
        check_slot(1'b0, 16'h0, t4);
        chk("restart_frame_len", 32'(t4 - t0), 32'd40);

        // Single digit, no dead time: always lit, updates only on 8-cycle boundaries
        sb1.push_back(7'b0000110);
        reset1 = 1'b0;
        tick();
        e1 = sb1.pop_front();
        chk("s1_first_an", 32'(an1), 32'd0);
        chk("s1_first_seg", 32'(seg1), 32'(e1));
        ok    = 1'b1;
        an_ok = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            if (k == 4) begin
                digits1 = 4'h5;
                sb1.push_back(7'b0100100);
            end
            tick();
            if (seg1 !== e1) ok = 1'b0;
            if (an1 !== 1'b0) an_ok = 1'b0;
        end
        chk("s1_hold", 32'(ok), 32'd1);
        tick();
        e1 = sb1.pop_front();
        chk("s1_next_seg", 32'(seg1), 32'(e1));
        ok = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (seg1 !== e1) ok = 1'b0;
            if (an1 !== 1'b0) an_ok = 1'b0;
        end
        chk("s1_hold2", 32'(ok), 32'd1);
        chk("s1_an_never_off", 32'(an_ok), 32'd1);
        chk("s1_idx", 32'(digit_idx1), 32'd0);
        chk("s1_dp", 32'(dp1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
